mul_seq: RTL and testbench
==========================

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 16 bits.
REQ-002 SHALL have port: i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: i_rst  input  1  synchronous active-high reset, sampled on rising edge of i_clk.
REQ-004 SHALL have port: i_start  input  1  request a multiply; accepted only in IDLE.
REQ-005 SHALL have port: i_a  input  16  multiplicand, sampled on the accepting edge.
REQ-006 SHALL have port: i_b  input  16  multiplier, sampled on the accepting edge.
REQ-007 SHALL have port: o_result  output  16  low 16 bits of i_a*i_b from the last completed operation.
REQ-008 SHALL have port: o_busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port: o_done  output  1  one-cycle completion pulse.

Function
REQ-010 SHALL compute a 16x16 shift-add multiply, keeping the low 16 bits (mod 2^16); the result is identical for signed and unsigned operands.
REQ-011 SHALL instantiate exactly one alu and use it for every P and M update: add = op 3'b001; left shift by 1 = op 3'b101 with ALU B operand 16'd1.
REQ-012 SHALL have no adder or shifter outside the alu on the P/M paths; the Q right shift is plain wiring (logical, zero fill).
REQ-013 SHALL hold internal registers P (product), M (multiplicand) and Q (multiplier), each 16 bits.
REQ-014 SHALL implement the FSM states IDLE, ADD, SHIFT and DONE.
REQ-015 IDLE: on i_start=1, load P=0, M=i_a, Q=i_b and go to ADD; with i_start=0, remain in IDLE.
REQ-016 ADD: if Q[0]=1, P <= alu(P + M); otherwise P is unchanged; always go to SHIFT.
REQ-017 SHIFT: M <= alu(M << 1) and Q <= Q >> 1; go to DONE if (Q >> 1) == 0, otherwise go to ADD.
REQ-018 DONE: o_result <= P and go unconditionally to IDLE.
REQ-019 o_done SHALL be 1 for exactly the one cycle spent in DONE and 0 otherwise.
REQ-020 o_busy SHALL be 1 in ADD and SHIFT and 0 in IDLE and DONE; it is registered, with no combinational path from i_start.
REQ-021 Iteration count SHALL be n = max(1, index of the highest set bit of i_b + 1), so 1 <= n <= 16.
REQ-022 Latency: with accepting edge E0, the FSM SHALL enter DONE at edge E0+2n and o_done SHALL be high in the cycle after that edge.
REQ-023 Latency values SHALL be: i_b=0 -> E0+2; i_b=0xFFFF -> E0+32 (maximum).
REQ-024 i_start SHALL be ignored in ADD, SHIFT and DONE: no restart and no operand resample; back-to-back starts are accepted no sooner than the IDLE cycle after DONE.
REQ-025 i_a and i_b SHALL be ignored after the accepting edge; changing them mid-operation does not affect the result.
REQ-026 o_result SHALL change only on the edge entering DONE (or on reset) and hold through IDLE and any later operation until that operation's DONE.
REQ-027 SHALL contain no unreachable state; any illegal state encoding returns to IDLE on the next edge.

Reset
REQ-028 i_rst=1 at a rising edge SHALL force state=IDLE, P=M=Q=0, o_result=0x0000, o_busy=0 and o_done=0.
REQ-029 Reset SHALL take priority over i_start and over every FSM transition.
REQ-030 Reset mid-operation SHALL abort the operation: no o_done pulse, and o_result becomes 0x0000.
REQ-031 The first i_start with i_rst=0 after reset SHALL be accepted normally.

Verification
REQ-032 Basic: i_a=3, i_b=5, start -> o_busy high for 6 cycles, o_done pulse after edge E0+6, o_result=0x000F.
REQ-033 Zero and maximum: i_b=0, i_a=0x1234 -> o_result=0x0000 with done after E0+2; i_a=i_b=0xFFFF -> o_result=0x0001 with done after E0+32.
REQ-034 Overflow and signed: 0x0100*0x0100 -> 0x0000 after E0+18; 0xFFFE*0x0003 -> 0xFFFA.
REQ-035 Start while busy: start 7*9, assert i_start with new operands at E0+3 -> ignored, single done, o_result=0x003F.
REQ-036 Reset mid-operation: reset at E0+5 of 0xFFFF*0xFFFF -> next cycle o_busy=0, o_done=0, o_result=0x0000; a following 2*2 -> 0x0004.
REQ-037 Random: 1000 random operand pairs SHALL match (a*b) mod 2^16, with done timing per REQ-022 and o_done high exactly one cycle per accepted start.

Source files
------------

// File: rtl/mul_seq.sv
// Sequential 16x16 shift-add multiplier (low 16 bits of the product).
// Every P and M update goes through a single shared alu instance.

module alu (
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  // operation decode
  always_comb begin
    y = 16'd0;
    case (op)
      3'b000:  y = a;
      3'b001:  y = a + b;
      3'b010:  y = a - b;
      3'b011:  y = a & b;
      3'b100:  y = a | b;
      3'b101:  y = a << b[3:0];
      3'b110:  y = a >> b[3:0];
      default: y = a ^ b;
    endcase
  end

endmodule

module mul_seq (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_result,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] p_r, p_s;
  logic [15:0] m_r, m_s;
  logic [15:0] q_r, q_s;
  logic [15:0] result_r, result_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [2:0]  alu_op_s;
  logic [15:0] alu_a_s, alu_b_s, alu_y_s;

  alu u_alu (
    .op (alu_op_s),
    .a  (alu_a_s),
    .b  (alu_b_s),
    .y  (alu_y_s)
  );

  // next-state, datapath and registered-output decode
  always_comb begin
    state_s  = state_r;
    p_s      = p_r;
    m_s      = m_r;
    q_s      = q_r;
    result_s = result_r;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    alu_op_s = 3'b001;
    alu_a_s  = p_r;
    alu_b_s  = m_r;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          p_s     = 16'd0;
          m_s     = i_a;
          q_s     = i_b;
          state_s = ADD;
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ADD: begin
        if (q_r[0]) begin
          p_s = alu_y_s;
        end else begin
          p_s = p_r;
        end
        state_s = SHIFT;
        busy_s  = 1'b1;
      end
      SHIFT: begin
        alu_op_s = 3'b101;
        alu_a_s  = m_r;
        alu_b_s  = 16'd1;
        m_s      = alu_y_s;
        q_s      = {1'b0, q_r[15:1]};
        // Done once no multiplier bits remain; P already holds the final sum.
        if (q_r[15:1] == 15'd0) begin
          state_s  = DONE;
          result_s = p_r;
          done_s   = 1'b1;
        end else begin
          state_s = ADD;
          busy_s  = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // state, datapath and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= IDLE;
      p_r      <= 16'd0;
      m_r      <= 16'd0;
      q_r      <= 16'd0;
      result_r <= 16'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      p_r      <= p_s;
      m_r      <= m_s;
      q_r      <= q_s;
      result_r <= result_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign o_result = result_r;
  assign o_busy   = busy_r;
  assign o_done   = done_r;

endmodule

// File: tb/tb_mul_seq.sv
// Directed-vector and random self-checking bench for mul_seq.

module tb_mul_seq;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_a = 16'd0;
  logic [15:0] i_b = 16'd0;
  logic [15:0] o_result;
  logic        o_busy;
  logic        o_done;

  int checks = 0;
  int errors = 0;

  mul_seq dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_result (o_result),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];
  logic [15:0] last_result;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch an operation (edge E0 is the next posedge) and watch it complete.
  // glitch_k >= 0 asserts a new start with other operands so it is sampled at E0+glitch_k+1.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input int exp_lat, input int glitch_k);
    int first_done;
    int done_cnt;
    int busy_cnt;
    int early_change;
    logic [15:0] res_at_done;
    first_done   = -1;
    done_cnt     = 0;
    busy_cnt     = 0;
    early_change = 0;
    res_at_done  = 16'd0;
    i_a = a;
    i_b = b;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_a = ~a;
    i_b = ~b;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge i_clk);
        #1;
      end
      if (k == glitch_k) begin
        i_start = 1'b1;
        i_a = 16'hFFFF;
        i_b = 16'hFFFF;
      end else begin
        i_start = 1'b0;
      end
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done  = k;
          res_at_done = o_result;
        end
      end
      if (first_done < 0 && o_result !== last_result) early_change++;
      if (first_done >= 0 && k >= first_done + 3) break;
    end
    i_start = 1'b0;
    check({name, " latency"}, first_done, exp_lat);
    check({name, " result"}, res_at_done, exp);
    check({name, " done_pulses"}, done_cnt, 1);
    check({name, " busy_cycles"}, busy_cnt, exp_lat);
    check({name, " result_hold"}, early_change, 0);
    check({name, " result_after"}, o_result, exp);
    last_result = exp;
  endtask

  function automatic int model_lat(input logic [15:0] b);
    int n;
    n = 1;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) n = i + 1;
    end
    return 2 * n;
  endfunction

  initial begin
    vecs[0] = '{a: 16'h0003, b: 16'h0005, exp: 16'h000F, lat: 6};
    vecs[1] = '{a: 16'h1234, b: 16'h0000, exp: 16'h0000, lat: 2};
    vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF, exp: 16'h0001, lat: 32};
    vecs[3] = '{a: 16'h0100, b: 16'h0100, exp: 16'h0000, lat: 18};
    vecs[4] = '{a: 16'hFFFE, b: 16'h0003, exp: 16'hFFFA, lat: 4};
    vecs[5] = '{a: 16'h0001, b: 16'h0001, exp: 16'h0001, lat: 2};
    vecs[6] = '{a: 16'hABCD, b: 16'h8000, exp: 16'h8000, lat: 32};
    vecs[7] = '{a: 16'h00FF, b: 16'h00FF, exp: 16'hFE01, lat: 16};
    vecs[8] = '{a: 16'h1234, b: 16'h0001, exp: 16'h1234, lat: 2};
    vecs[9] = '{a: 16'h0007, b: 16'h0009, exp: 16'h003F, lat: 8};
    last_result = 16'h0000;

    // reset state
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset result", o_result, 16'h0000);
    check("reset busy", o_busy, 1'b0);
    check("reset done", o_done, 1'b0);
    i_rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      run_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].lat, -1);
    end

    // start while busy: new start sampled at E0+3 must be ignored
    run_op("start_busy", 16'h0007, 16'h0009, 16'h003F, 8, 2);

    // reset mid-operation at E0+5
    i_a = 16'hFFFF;
    i_b = 16'hFFFF;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    check("midrst busy_before", o_busy, 1'b1);
    check("midrst result_before", o_result, 16'h003F);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("midrst busy", o_busy, 1'b0);
    check("midrst done", o_done, 1'b0);
    check("midrst result", o_result, 16'h0000);
    begin
      int stray;
      stray = 0;
      for (int k = 0; k < 35; k++) begin
        @(posedge i_clk);
        #1;
        if (o_done || o_busy) stray++;
      end
      check("midrst no_done", stray, 0);
    end
    last_result = 16'h0000;
    run_op("after_rst", 16'h0002, 16'h0002, 16'h0004, 4, -1);

    // random operands against the arithmetic model
    for (int r = 0; r < 1000; r++) begin
      logic [15:0] ra, rb;
      logic [31:0] prod;
      ra = 16'($urandom());
      rb = 16'($urandom());
      if (r % 4 == 1) rb = rb >> $urandom_range(15, 0);
      prod = ra * rb;
      run_op($sformatf("rnd%0d", r), ra, rb, prod[15:0], model_lat(rb), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
